// File: rtl/dm_byte_ram.sv
// Purpose : MEM-stage data memory. Performs lane-aligned byte, half and word stores,
//           returns sign- or zero-extended loads, and clears itself after reset.
// Latency : stores land at the request edge; load data and rdata_valid/addr_err are registered (1 cycle).
// Backpr. : none; busy is high during the post-reset clear and all requests are ignored meanwhile.
// Ports   : clk, reset_n (async, active low); we/re store/load request; addr byte address;
//           be byte enables; wdata right-justified store data; ld_type 1=lb 2=lbu 3=lh 4=lhu 5=lw;
//           rdata registered load result; rdata_valid / addr_err one-cycle pulses; busy clearing flag.
module dm_byte_ram #(
  parameter int          DEPTH_W = 1024,
  parameter int          AW      = 10,
  parameter logic [31:0] BASE    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_type,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        addr_err,
  output logic        busy
);

  localparam logic [31:0] LIM = 32'(DEPTH_W) << 2;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_idx, w_idx_nxt;
  logic            w_clr_we;

  logic [31:0]     r_mem [DEPTH_W];
  logic [31:0]     r_rdata;
  logic            r_vld;
  logic            r_err;

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_clr_we    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we  = 1'b1;
        w_idx_nxt = r_idx + AW'(1);
        if (r_idx == AW'(DEPTH_W - 1)) w_state_nxt = S_READY;
      end
      default: ;
    endcase
  end

  assign busy = (r_state == S_CLEAR);

  // ---------------- request decode ----------------
  logic [31:0]   w_off;
  logic          w_oor;
  logic          w_st_word, w_st_half;
  logic          w_ld_ok, w_ld_half, w_ld_word;
  logic          w_st_req, w_ld_req;
  logic          w_mis, w_err, w_st_go, w_ld_go;
  logic [AW-1:0] w_widx;

  assign w_off     = addr - BASE;
  assign w_oor     = (w_off >= LIM);
  assign w_widx    = w_off[AW+1:2];

  assign w_st_word = (be == 4'b1111);
  assign w_st_half = (be == 4'b0011) || (be == 4'b1100);
  assign w_ld_ok   = (ld_type >= 3'd1) && (ld_type <= 3'd5);
  assign w_ld_half = (ld_type == 3'd3) || (ld_type == 3'd4);
  assign w_ld_word = (ld_type == 3'd5);

  // A store with no lanes enabled is a silent no-op; a concurrent store always wins over a load.
  assign w_st_req  = !busy && we && (be != 4'b0000);
  assign w_ld_req  = !busy && re && !we && w_ld_ok;

  // Alignment is judged by the size of whichever access is actually being performed.
  assign w_mis = w_st_req ? ((w_st_half && addr[0]) || (w_st_word && (addr[1:0] != 2'b00)))
                          : ((w_ld_half && addr[0]) || (w_ld_word && (addr[1:0] != 2'b00)));
  assign w_err   = (w_st_req || w_ld_req) && (w_oor || w_mis);
  assign w_st_go = w_st_req && !w_err;
  assign w_ld_go = w_ld_req && !w_err;

  // Right-justified store data replicated across lanes; be then picks the lanes that land.
  logic [31:0] w_lane;
  always_comb begin
    w_lane = {4{wdata[7:0]}};
    if (w_st_word)      w_lane = wdata;
    else if (w_st_half) w_lane = {2{wdata[15:0]}};
  end

  // ---------------- storage (no reset: cleared by the sequencer) ----------------
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_idx] <= '0;
    end else if (w_st_go) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) r_mem[w_widx][8*i +: 8] <= w_lane[8*i +: 8];
      end
    end
  end

  // ---------------- load extraction ----------------
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_word = r_mem[w_widx];
  assign w_half = addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_byte = w_word[7:0];
    case (addr[1:0])
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  always_comb begin
    w_ext = w_word;
    case (ld_type)
      3'd1:    w_ext = {{24{w_byte[7]}}, w_byte};
      3'd2:    w_ext = {24'd0, w_byte};
      3'd3:    w_ext = {{16{w_half[15]}}, w_half};
      3'd4:    w_ext = {16'd0, w_half};
      default: w_ext = w_word;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_vld <= w_ld_go;
      r_err <= w_err;
      if (w_ld_go) r_rdata <= w_ext;
    end
  end

  assign rdata       = r_rdata;
  assign rdata_valid = r_vld;
  assign addr_err    = r_err;

endmodule

// File: tb/tb_dm_byte_ram.sv
// Purpose : self-checking bench for dm_byte_ram (DEPTH_W=16) with directed and random traffic.
// Latency : checks outputs 1 ns after the edge that consumed each request.
// Backpr. : waits on busy with a bounded cycle budget.
module tb_dm_byte_ram;

  localparam int          DW     = 16;
  localparam int          AWP    = 4;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          NBYTES = DW * 4;

  logic        clk;
  logic        reset_n;
  logic        we, re;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [2:0]  ld_type;
  logic [31:0] rdata;
  logic        rdata_valid, addr_err, busy;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mdl [DW];
  logic [31:0] last_rd;

  dm_byte_ram #(.DEPTH_W(DW), .AW(AWP), .BASE(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .re(re), .addr(addr), .be(be),
    .wdata(wdata), .ld_type(ld_type), .rdata(rdata), .rdata_valid(rdata_valid),
    .addr_err(addr_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DW; i++) mdl[i] = 32'd0;
  endtask

  // One request cycle: expectations come from the byte-level memory model.
  task automatic op(input logic w, input logic r, input logic [31:0] a, input logic [3:0] b,
                    input logic [31:0] d, input logic [2:0] lt, input string tag);
    logic        st, ld, err;
    int          sz, wi;
    logic [31:0] off, v, tmp;
    st  = w && (b != 4'd0);
    ld  = r && !w && (lt >= 3'd1) && (lt <= 3'd5);
    sz  = 1;
    if (st)      sz = $countones(b);
    else if (ld) sz = (lt <= 3'd2) ? 1 : (lt <= 3'd4) ? 2 : 4;
    off = a - BASE;
    err = (st || ld) && ((off >= NBYTES) || ((a % sz) != 0));
    we = w; re = r; addr = a; be = b; wdata = d; ld_type = lt;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; be = 4'd0; ld_type = 3'd0;
    wi = int'(off / 4);
    if (ld && !err) begin
      v = mdl[wi] >> (8 * (a % 4));
      if (sz == 1) begin
        v = v & 32'hFF;
        if (lt == 3'd1 && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2) begin
        v = v & 32'hFFFF;
        if (lt == 3'd3 && v[15]) v = v | 32'hFFFF_0000;
      end
      last_rd = v;
    end
    chk({tag, "/vld"},   rdata_valid, ld && !err);
    chk({tag, "/err"},   addr_err, err);
    chk({tag, "/rdata"}, rdata, last_rd);
    if (st && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) begin
          tmp = d >> (8 * (i % sz));
          mdl[wi][8*i +: 8] = tmp[7:0];
        end
      end
    end
  endtask

  task automatic lw_all(input string tag);
    for (int i = 0; i < DW; i++) op(1'b0, 1'b1, BASE + 32'(i * 4), 4'd0, 32'd0, 3'd5, tag);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  logic [3:0] bes [8];
  int         nb;
  int         kind;
  logic [31:0] ra;
  logic [3:0]  rb;

  initial begin
    bes = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0000};
    reset_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; be = '0; wdata = '0; ld_type = '0;
    last_rd = 32'd0;
    model_clear();

    // Reset values
    repeat (3) @(posedge clk); #1;
    chk("rst/rdata", rdata, 32'd0);
    chk("rst/vld",   rdata_valid, 1'b0);
    chk("rst/err",   addr_err, 1'b0);
    chk("rst/busy",  busy, 1'b1);

    // 1: clear lasts exactly DEPTH_W cycles, then everything reads 0
    reset_n = 1'b1;
    count_busy(nb);
    chk("t1/busy_len", nb, 32'd16);
    lw_all("t1/lw");

    // 2: word store then load
    op(1'b1, 1'b0, 32'h8, 4'b1111, 32'hDEADBEEF, 3'd0, "t2/sw");
    op(1'b0, 1'b1, 32'h8, 4'd0, 32'd0, 3'd5, "t2/lw");
    chk("t2/spec", rdata, 32'hDEADBEEF);
    op(1'b0, 1'b0, 32'h8, 4'd0, 32'd0, 3'd0, "t2/idle");

    // 3: byte store into lane 1
    op(1'b1, 1'b0, 32'h9, 4'b0010, 32'h000000A5, 3'd0, "t3/sb");
    op(1'b0, 1'b1, 32'h8, 4'd0, 32'd0, 3'd5, "t3/lw");
    chk("t3/lw_spec", rdata, 32'hDEADA5EF);
    op(1'b0, 1'b1, 32'h9, 4'd0, 32'd0, 3'd1, "t3/lb");
    chk("t3/lb_spec", rdata, 32'hFFFFFFA5);
    op(1'b0, 1'b1, 32'h9, 4'd0, 32'd0, 3'd2, "t3/lbu");
    chk("t3/lbu_spec", rdata, 32'h000000A5);

    // 4: half store into upper half
    op(1'b1, 1'b0, 32'hA, 4'b1100, 32'h00008001, 3'd0, "t4/sh");
    op(1'b0, 1'b1, 32'hA, 4'd0, 32'd0, 3'd3, "t4/lh");
    chk("t4/lh_spec", rdata, 32'hFFFF8001);
    op(1'b0, 1'b1, 32'hA, 4'd0, 32'd0, 3'd4, "t4/lhu");
    chk("t4/lhu_spec", rdata, 32'h00008001);
    op(1'b0, 1'b1, 32'h8, 4'd0, 32'd0, 3'd5, "t4/lw");
    chk("t4/lw_spec", rdata, 32'h8001A5EF);

    // 5: misaligned / out-of-range accesses
    op(1'b0, 1'b1, 32'h6, 4'd0, 32'd0, 3'd5, "t5/lw_mis");
    op(1'b0, 1'b1, 32'h3, 4'd0, 32'd0, 3'd3, "t5/lh_mis");
    op(1'b1, 1'b0, BASE + NBYTES, 4'b1111, 32'h12345678, 3'd0, "t5/sw_oor");
    op(1'b1, 1'b0, 32'h4, 4'b0000, 32'hFFFFFFFF, 3'd0, "t5/we_be0");
    op(1'b0, 1'b1, 32'h4, 4'd0, 32'd0, 3'd7, "t5/bad_ldtype");
    op(1'b1, 1'b1, 32'h0, 4'b1111, 32'hCAFEF00D, 3'd5, "t5/we_and_re");
    lw_all("t5/lw");

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      kind = $urandom_range(0, 9);
      ra   = 32'($urandom_range(0, NBYTES + 15));
      if ($urandom_range(0, 1) == 1) ra = ra & ~32'd3;
      rb   = bes[$urandom_range(0, 7)];
      op(kind <= 3 || kind == 9, kind >= 4, ra, rb, $urandom, 3'($urandom_range(0, 7)), "rand");
    end
    lw_all("rand/lw");

    // 6: reset mid-clear restarts from idx 0; stores during busy are ignored
    reset_n = 1'b0; #2; reset_n = 1'b1;
    repeat (7) @(posedge clk); #1;
    reset_n = 1'b0; #1;
    last_rd = 32'd0;
    chk("t6/rst_busy",  busy, 1'b1);
    chk("t6/rst_rdata", rdata, 32'd0);
    #2; reset_n = 1'b1;
    we = 1'b1; addr = 32'h0; be = 4'b1111; wdata = 32'h12345678;
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(posedge clk); #1;
      chk("t6/no_err", addr_err, 1'b0);
      chk("t6/no_vld", rdata_valid, 1'b0);
    end
    we = 1'b0; be = 4'd0;
    chk("t6/busy_len", nb, 32'd16);
    model_clear();
    lw_all("t6/lw");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
